// File: rtl/fetch_queue_if.sv
// fetch_queue bus: imem read port plus the decode-side pop handshake.
// master = the queue, slave = memory/decode side (testbench).
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns fetch PC, issues in-order imem reads,
// buffers {pc, inst} for decode; redirect flushes and drops in-flight reads.
// Ports: clk, rst (sync, active-high), bus (fetch_queue_if.master).
// Option: FETCH_QUEUE_BYPASS_EN forwards a kept response straight to out_*
// when the queue is empty.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;

    logic credit;
    logic grant;
    logic keep;
    logic push;
    logic pop;
    logic head_valid;
    logic byp_take;

    // Reserve a queue slot for every read in flight so pushes never overflow.
    assign credit = (32'(count) + 32'(outstanding)) < 32'(DEPTH);

    assign bus.imem_req  = !rst && !bus.redirect && credit &&
                           (32'(outstanding) < 32'(MAX_OUT));
    assign bus.imem_addr = fetch_pc;

    assign grant      = bus.imem_req && bus.imem_gnt;
    assign keep       = bus.imem_rvalid && (discard == '0) && !bus.redirect;
    assign head_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic byp;
    assign byp           = keep && !head_valid;
    assign byp_take      = byp && bus.out_ready;
    assign bus.out_valid = head_valid || byp;
    assign bus.out_inst  = head_valid ? inst_mem[rd_ptr] :
                           (byp ? bus.imem_rdata : 32'd0);
    assign bus.out_pc    = head_valid ? pc_mem[rd_ptr] :
                           (byp ? rsp_pc : 32'd0);
`else
    assign byp_take      = 1'b0;
    assign bus.out_valid = head_valid;
    assign bus.out_inst  = head_valid ? inst_mem[rd_ptr] : 32'd0;
    assign bus.out_pc    = head_valid ? pc_mem[rd_ptr] : 32'd0;
`endif

    assign push = keep && !byp_take;
    assign pop  = head_valid && bus.out_ready && !bus.redirect;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            inst_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else if (bus.redirect) begin
            // No grant this cycle (req is low), so every read still
            // outstanding after this edge is stale.
            fetch_pc    <= bus.redirect_pc;
            rsp_pc      <= bus.redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - OW'(bus.imem_rvalid);
            discard     <= outstanding - OW'(bus.imem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd1;
            end
            outstanding <= outstanding + OW'(grant) - OW'(bus.imem_rvalid);
            if (bus.imem_rvalid) begin
                if (discard != '0) begin
                    discard <= discard - OW'(1);
                end else begin
                    rsp_pc <= rsp_pc + 32'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small variable-latency imem model.
// DEPTH=4, MAX_OUT=2, RESET_PC=0.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if bus();

    fetch_queue #(
        .DEPTH(4),
        .MAX_OUT(2),
        .RESET_PC(32'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    // imem model: fixed latency 1..3 cycles after grant, in order.
    int          lat = 1;
    logic [2:0]  mv;
    logic [31:0] ma [3];
    always @(posedge clk) begin
        if (rst) begin
            mv <= 3'b000;
        end else begin
            mv <= {mv[1:0], bus.imem_req && bus.imem_gnt};
        end
        ma[0] <= bus.imem_addr;
        ma[1] <= ma[0];
        ma[2] <= ma[1];
    end
    assign bus.imem_rvalid = (lat == 1) ? mv[0] : (lat == 2) ? mv[1] : mv[2];
    assign bus.imem_rdata  = inst_of((lat == 1) ? ma[0] :
                                     (lat == 2) ? ma[1] : ma[2]);

    logic [31:0] popq [$];
    logic [31:0] popi [$];
    logic [31:0] gntq [$];
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready && !bus.redirect) begin
                popq.push_back(bus.out_pc);
                popi.push_back(bus.out_inst);
            end
            if (bus.imem_req && bus.imem_gnt)
                gntq.push_back(bus.imem_addr);
            if (bus.imem_rvalid)
                check("rsp_outstanding", 32'(dut.outstanding != 0), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(int l, logic rdy);
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.imem_gnt    = 1'b1;
        bus.out_ready   = rdy;
        lat             = l;
        tick();
        tick();
        rst = 1'b0;
        popq.delete();
        popi.delete();
        gntq.delete();
    endtask

    task automatic check_first_pop(string tag, logic [31:0] pc);
        check({tag, "_npop"}, 32'(popq.size() > 0), 32'd1);
        if (popq.size() > 0) begin
            check({tag, "_pc"}, popq[0], pc);
            check({tag, "_inst"}, popi[0], inst_of(pc));
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.out_ready   = 1'b1;
        tick();
        tick();
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_inst", bus.out_inst, 32'd0);
        check("rst_pc", bus.out_pc, 32'd0);

        // Streaming from reset, 1-cycle memory.
        reset_dut(1, 1'b1);
        #1;
        check("first_req", 32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr, 32'd0);
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            #1;
            check("b2b_valid", 32'(bus.out_valid), 32'd1);
        end
        check("stream_npop", 32'(popq.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < popq.size(); i++) begin
            check("stream_pc", popq[i], 32'(i));
            check("stream_inst", popi[i], inst_of(32'(i)));
        end

        // Decode stall: exactly four reads fill the queue.
        reset_dut(1, 1'b0);
        repeat (10) tick();
        #1;
        check("stall_ngnt", 32'(gntq.size()), 32'd4);
        for (int i = 0; i < 4 && i < gntq.size(); i++)
            check("stall_gnt_addr", gntq[i], 32'(i));
        check("stall_req", 32'(bus.imem_req), 32'd0);
        check("stall_count", 32'(dut.count), 32'd4);
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_nopop", 32'(popq.size()), 32'd0);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check("drain_npop", 32'(popq.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < popq.size(); i++) begin
            check("drain_pc", popq[i], 32'(i));
            check("drain_inst", popi[i], inst_of(32'(i)));
        end

        // Redirect with two reads in flight (3-cycle memory).
        reset_dut(3, 1'b1);
        tick();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        #1;
        check("rd2_req", 32'(bus.imem_req), 32'd0);
        check("rd2_outst", 32'(dut.outstanding), 32'd2);
        check("rd2_rvalid", 32'(bus.imem_rvalid), 32'd0);
        tick();
        bus.redirect = 1'b0;
        #1;
        check("rd2_discard", 32'(dut.discard), 32'd2);
        check("rd2_valid", 32'(bus.out_valid), 32'd0);
        repeat (12) tick();
        check("rd2_discard_end", 32'(dut.discard), 32'd0);
        check("rd2_ngnt", 32'(gntq.size() >= 3), 32'd1);
        if (gntq.size() >= 3)
            check("rd2_gnt_addr", gntq[2], 32'h40);
        check_first_pop("rd2", 32'h40);

        // Redirect coinciding with a response and a pop.
        reset_dut(1, 1'b1);
        repeat (4) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        #1;
`ifndef FETCH_QUEUE_BYPASS_EN
        check("rd1_pre_valid", 32'(bus.out_valid), 32'd1);
`endif
        check("rd1_pre_rvalid", 32'(bus.imem_rvalid), 32'd1);
        tick();
        bus.redirect = 1'b0;
        popq.delete();
        popi.delete();
        #1;
        check("rd1_valid", 32'(bus.out_valid), 32'd0);
        check("rd1_count", 32'(dut.count), 32'd0);
        check("rd1_req", 32'(bus.imem_req), 32'd1);
        check("rd1_addr", bus.imem_addr, 32'h80);
`ifndef FETCH_QUEUE_BYPASS_EN
        tick();
        #1;
        check("rd1_lat_n2", 32'(bus.out_valid), 32'd0);
        tick();
        #1;
        check("rd1_lat_n3", 32'(bus.out_valid), 32'd1);
        check("rd1_lat_pc", bus.out_pc, 32'h80);
`endif
        repeat (3) tick();
        check_first_pop("rd1", 32'h80);

        // Grant stall after a redirect to 0x100.
        bus.imem_gnt    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("gstall_req", 32'(bus.imem_req), 32'd1);
            check("gstall_addr", bus.imem_addr, 32'h100);
            check("gstall_fpc", dut.fetch_pc, 32'h100);
            tick();
        end
        bus.imem_gnt = 1'b1;
        popq.delete();
        popi.delete();
        repeat (4) tick();
        check_first_pop("gstall", 32'h100);

        // Reset mid-stream.
        rst = 1'b1;
        tick();
        #1;
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_pc", bus.out_pc, 32'd0);
        check("mrst_inst", bus.out_inst, 32'd0);
        check("mrst_req", 32'(bus.imem_req), 32'd0);
        rst = 1'b0;
        popq.delete();
        popi.delete();
        #1;
        check("mrst_req_after", 32'(bus.imem_req), 32'd1);
        check("mrst_addr_after", bus.imem_addr, 32'd0);
        repeat (4) tick();
        check_first_pop("mrst", 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue: response forwarded in the same cycle.
        reset_dut(1, 1'b1);
        tick();
        #1;
        check("byp_valid", 32'(bus.out_valid), 32'd1);
        check("byp_pc", bus.out_pc, 32'd0);
        check("byp_inst", bus.out_inst, inst_of(32'd0));
        check("byp_count", 32'(dut.count), 32'd0);
        tick();
        #1;
        check("byp_count_next", 32'(dut.count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
